// File: rtl/video_pkg.sv
// ============================================================================
// Module : video_pkg
// Brief  : Shared constants and colour-expansion helpers for the line buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package video_pkg;

   localparam int HACTIVE_704 = 704;
   localparam int HACTIVE_640 = 640;
   localparam int SRC_W       = 256;
   localparam int SRC_H       = 240;
   localparam int SRC_LINES   = 263;
   localparam int BORDER_704  = 96;
   localparam int BORDER_640  = 64;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   function automatic logic [3:0] expand2(input logic [1:0] c);
      return {c, c};
   endfunction

   // BBGGRR source pixel to 4:4:4 output
   function automatic rgb444_t expand_bbggrr(input logic [5:0] p);
      rgb444_t v;
      v.r = expand2(p[1:0]);
      v.g = expand2(p[3:2]);
      v.b = expand2(p[5:4]);
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/video_linebuf_if.sv
// ============================================================================
// Module : video_linebuf_if
// Brief  : Timing, renderer-write and VGA output bundle of the line buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface video_linebuf_if;

   logic       i_mode;
   logic [9:0] i_hpos;
   logic       i_hsync;
   logic       i_vsync;
   logic       i_hblank;
   logic       i_vblank;
   logic       i_vnext;
   logic       i_vnewframe;
   logic       i_voddline;
   logic [5:0] i_border;
   logic       i_wr_en;
   logic [7:0] i_wr_idx;
   logic [5:0] i_wr_data;
   logic       o_render_start;
   logic [7:0] o_render_line;
   logic [3:0] o_vga_r;
   logic [3:0] o_vga_g;
   logic [3:0] o_vga_b;
   logic       o_vga_hsync;
   logic       o_vga_vsync;

   modport slave (
      input  i_mode, i_hpos, i_hsync, i_vsync, i_hblank, i_vblank,
             i_vnext, i_vnewframe, i_voddline, i_border,
             i_wr_en, i_wr_idx, i_wr_data,
      output o_render_start, o_render_line,
             o_vga_r, o_vga_g, o_vga_b, o_vga_hsync, o_vga_vsync
   );

   modport master (
      output i_mode, i_hpos, i_hsync, i_vsync, i_hblank, i_vblank,
             i_vnext, i_vnewframe, i_voddline, i_border,
             i_wr_en, i_wr_idx, i_wr_data,
      input  o_render_start, o_render_line,
             o_vga_r, o_vga_g, o_vga_b, o_vga_hsync, o_vga_vsync
   );

endinterface

`default_nettype wire

// File: rtl/video_linebuf_ram.sv
// ============================================================================
// Module : linebuf_ram
// Brief  : Simple dual-port RAM, one write port and one registered read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module linebuf_ram #(
   parameter int DEPTH = 512,
   parameter int WIDTH = 6,
   parameter int AW    = 9
) (
   input  wire logic             clk,
   input  wire logic             i_we,
   input  wire logic [AW-1:0]    i_waddr,
   input  wire logic [WIDTH-1:0] i_wdata,
   input  wire logic [AW-1:0]    i_raddr,
   output logic      [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // No reset on purpose so the array maps onto block RAM
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule

`default_nettype wire

// File: rtl/video_linebuf.sv
// ============================================================================
// Module : video_linebuf
// Brief  : Ping-pong scan-line buffer, 2x horizontal replay with border and
//          BBGGRR->RGB444 expansion. SCANLINES_EN dims the odd VGA line.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module video_linebuf
   import video_pkg::*;
#(
   parameter int ACTIVE_W = 512,
   parameter int LAT      = 2
) (
   input  wire logic        clk,
   input  wire logic        rst,
   video_linebuf_if.slave   bus
);

   logic          r_sel;
   logic          r_mode;
   logic [8:0]    r_line;
   logic          r_render_start;
   logic [7:0]    r_render_line;

   logic [8:0]    w_line_next;
   logic [8:0]    w_render_n;

   logic [9:0]    w_left;
   logic [9:0]    w_diff;
   logic [7:0]    w_rd_idx;
   logic          w_blank;
   logic          w_active;
   logic [5:0]    w_rd_data;

   logic          r_active1;
   logic          r_blank1;
   logic          r_odd1;
   logic [5:0]    r_border1;

   logic [5:0]    w_pix;
   rgb444_t       w_rgb;
   rgb444_t       r_rgb;

   logic [LAT-1:0] r_hs_d;
   logic [LAT-1:0] r_vs_d;

   // ------------------------------------------------------------------
   // Line sequencing
   // ------------------------------------------------------------------
   assign w_line_next = (r_line == 9'(SRC_LINES - 1)) ? 9'd0 : r_line + 9'd1;
   assign w_render_n  = (w_line_next == 9'(SRC_LINES - 1)) ? 9'd0 : w_line_next + 9'd1;

   // Line n+1 is rendered while line n is displayed, so line 0 preloads on 262
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel          <= 1'b0;
         r_mode         <= 1'b0;
         r_line         <= 9'd0;
         r_render_start <= 1'b0;
         r_render_line  <= 8'd0;
      end else begin
         r_render_start <= 1'b0;
         if (bus.i_vnext) begin
            r_sel  <= ~r_sel;
            r_mode <= bus.i_mode;
         end
         if (bus.i_vnewframe) begin
            r_line <= 9'd241;
         end else if (bus.i_vnext) begin
            r_line <= w_line_next;
            if (w_render_n < 9'(SRC_H)) begin
               r_render_start <= 1'b1;
               r_render_line  <= w_render_n[7:0];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Cycle 0: address generation
   // ------------------------------------------------------------------
   assign w_left   = r_mode ? 10'(BORDER_640) : 10'(BORDER_704);
   assign w_blank  = bus.i_hblank | bus.i_vblank;
   assign w_active = !w_blank && (bus.i_hpos >= w_left) &&
                     ({1'b0, bus.i_hpos} < ({1'b0, w_left} + 11'(ACTIVE_W)));
   assign w_diff   = bus.i_hpos - w_left;
   assign w_rd_idx = w_diff[8:1];

   // Writes always land in the buffer that is back before any swap this cycle
   linebuf_ram #(
      .DEPTH (2 * SRC_W),
      .WIDTH (6),
      .AW    (9)
   ) u_ram (
      .clk     (clk),
      .i_we    (bus.i_wr_en),
      .i_waddr ({~r_sel, bus.i_wr_idx}),
      .i_wdata (bus.i_wr_data),
      .i_raddr ({r_sel, w_rd_idx}),
      .o_rdata (w_rd_data)
   );

   // ------------------------------------------------------------------
   // Cycle 1: qualifiers aligned with RAM data
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active1 <= 1'b0;
         r_blank1  <= 1'b1;
         r_border1 <= 6'd0;
         r_odd1    <= 1'b0;
      end else begin
         r_active1 <= w_active;
         r_blank1  <= w_blank;
         r_border1 <= bus.i_border;
         r_odd1    <= bus.i_voddline;
      end
   end

   always_comb begin
      w_pix = r_active1 ? w_rd_data : r_border1;
      w_rgb = expand_bbggrr(w_pix);
`ifdef SCANLINES_EN
      if (r_odd1) begin
         w_rgb.r = w_rgb.r >> 1;
         w_rgb.g = w_rgb.g >> 1;
         w_rgb.b = w_rgb.b >> 1;
      end
`endif
      if (r_blank1) begin
         w_rgb = '0;
      end
   end

   // ------------------------------------------------------------------
   // Cycle 2: output registers and matching sync delay
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rgb  <= '0;
         r_hs_d <= '1;
         r_vs_d <= '1;
      end else begin
         r_rgb <= w_rgb;
         for (int i = LAT - 1; i > 0; i--) begin
            r_hs_d[i] <= r_hs_d[i-1];
            r_vs_d[i] <= r_vs_d[i-1];
         end
         r_hs_d[0] <= bus.i_hsync;
         r_vs_d[0] <= bus.i_vsync;
      end
   end

   assign bus.o_vga_r        = r_rgb.r;
   assign bus.o_vga_g        = r_rgb.g;
   assign bus.o_vga_b        = r_rgb.b;
   assign bus.o_vga_hsync    = r_hs_d[LAT-1];
   assign bus.o_vga_vsync    = r_vs_d[LAT-1];
   assign bus.o_render_start = r_render_start;
   assign bus.o_render_line  = r_render_line;

`ifdef SCANLINES_EN
   logic w_unused;
   assign w_unused = ^{w_diff[9], w_diff[0]};
`else
   logic w_unused;
   assign w_unused = ^{w_diff[9], w_diff[0], r_odd1};
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_linebuf.sv
// ============================================================================
// Module : tb_video_linebuf
// Brief  : Scoreboard bench for video_linebuf against a behavioural line model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_video_linebuf;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   video_linebuf_if bus();

   video_linebuf #(.ACTIVE_W(512), .LAT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          tag;
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      bit          chk_rgb;
   } vexp_t;

   typedef struct {
      int       tag;
      logic     rs;
      logic [7:0] rl;
   } rexp_t;

   vexp_t vq[$];
   rexp_t rq[$];
   vexp_t ve;
   rexp_t re;

   int ecnt   = 0;
   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [5:0] mbuf  [2][256];
   bit         mknown[2][256];
   int msel, mline, mmode, mrs, mrl;

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", nm, ecnt, act, exp);
      end
   endtask

   function automatic logic [11:0] model_rgb(input int pix, input bit dim);
      int c [3];
      for (int ch = 0; ch < 3; ch++) begin
         c[ch] = ((pix >> (2 * ch)) % 4) * 5;
         if (dim) c[ch] = c[ch] / 2;
      end
      return {4'(c[0]), 4'(c[1]), 4'(c[2])};
   endfunction

   task automatic model_reset();
      msel = 0; mline = 0; mmode = 0; mrs = 0; mrl = 0;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 256; i++) mknown[b][i] = 0;
   endtask

   // Derive expectations from the inputs now on the bus, then advance the model
   task automatic commit();
      int L, hp, pix, x, n;
      bit blank, act, known, dim;
      logic [11:0] rgb;
      L     = (mmode != 0) ? 64 : 96;
      hp    = int'(bus.i_hpos);
      blank = bus.i_hblank || bus.i_vblank;
      act   = !blank && hp >= L && hp < L + 512;
      known = 1;
      if (act) begin
         x     = (hp - L) / 2;
         pix   = int'(mbuf[msel][x]);
         known = mknown[msel][x];
      end else begin
         pix = int'(bus.i_border);
      end
`ifdef SCANLINES_EN
      dim = bus.i_voddline;
`else
      dim = 0;
`endif
      rgb = blank ? 12'h000 : model_rgb(pix, dim);
      vq.push_back('{ecnt + 2, rgb, bus.i_hsync, bus.i_vsync, known || blank});

      if (bus.i_wr_en) begin
         mbuf[1 - msel][bus.i_wr_idx]   = bus.i_wr_data;
         mknown[1 - msel][bus.i_wr_idx] = 1;
      end
      mrs = 0;
      if (bus.i_vnext) begin
         msel  = 1 - msel;
         mmode = int'(bus.i_mode);
      end
      if (bus.i_vnewframe) begin
         mline = 241;
      end else if (bus.i_vnext) begin
         mline = (mline + 1) % 263;
         n = (mline + 1) % 263;
         if (n < 240) begin
            mrs = 1;
            mrl = n;
         end
      end
      rq.push_back('{ecnt + 1, 1'(mrs), 8'(mrl)});
   endtask

   task automatic step();
      commit();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.i_wr_en     = 1'b0;
      bus.i_vnext     = 1'b0;
      bus.i_vnewframe = 1'b0;
   endtask

   // One scan line of hpos with random back-buffer writes
   task automatic sweep(input int act_w);
      for (int h = 0; h < 800; h++) begin
         bus.i_hpos      = 10'(h);
         bus.i_hblank    = (h >= act_w);
         bus.i_vblank    = 1'b0;
         bus.i_hsync     = !(h >= 720 && h < 760);
         bus.i_vsync     = 1'($urandom_range(0, 1));
         bus.i_voddline  = 1'(h / 400);
         bus.i_wr_en     = 1'($urandom_range(0, 1));
         bus.i_wr_idx    = 8'($urandom_range(0, 255));
         bus.i_wr_data   = 6'($urandom_range(0, 63));
         step();
      end
      idle_inputs();
   endtask

   task automatic pulse_vnext();
      bus.i_vnext = 1'b1;
      step();
      bus.i_vnext = 1'b0;
   endtask

   // Monitor: compare whenever an expected output is due
   always @(negedge clk) begin
      if (!rst) begin
         if (vq.size() > 0 && vq[0].tag == ecnt) begin
            ve = vq.pop_front();
            if (ve.chk_rgb)
               chk("rgb", int'({bus.o_vga_r, bus.o_vga_g, bus.o_vga_b}), int'(ve.rgb));
            chk("vga_hsync", int'(bus.o_vga_hsync), int'(ve.hs));
            chk("vga_vsync", int'(bus.o_vga_vsync), int'(ve.vs));
         end
         if (rq.size() > 0 && rq[0].tag == ecnt) begin
            re = rq.pop_front();
            chk("render_start", int'(bus.o_render_start), int'(re.rs));
            chk("render_line", int'(bus.o_render_line), int'(re.rl));
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_r"},      int'(bus.o_vga_r), 0);
      chk({tag, "_g"},      int'(bus.o_vga_g), 0);
      chk({tag, "_b"},      int'(bus.o_vga_b), 0);
      chk({tag, "_hsync"},  int'(bus.o_vga_hsync), 1);
      chk({tag, "_vsync"},  int'(bus.o_vga_vsync), 1);
      chk({tag, "_rstart"}, int'(bus.o_render_start), 0);
      chk({tag, "_rline"},  int'(bus.o_render_line), 0);
   endtask

   initial begin
      bus.i_mode = 1'b0;   bus.i_hpos = '0;      bus.i_hsync = 1'b1;
      bus.i_vsync = 1'b1;  bus.i_hblank = 1'b1;  bus.i_vblank = 1'b0;
      bus.i_vnext = 1'b0;  bus.i_vnewframe = 1'b0; bus.i_voddline = 1'b0;
      bus.i_border = '0;   bus.i_wr_en = 1'b0;   bus.i_wr_idx = '0;
      bus.i_wr_data = '0;
      model_reset();

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Known ramp into the back buffer, then make it front in 704 mode
      for (int i = 0; i < 256; i++) begin
         bus.i_hpos    = 10'(i);
         bus.i_wr_en   = 1'b1;
         bus.i_wr_idx  = 8'(i);
         bus.i_wr_data = 6'(i % 64);
         step();
      end
      idle_inputs();
      bus.i_mode = 1'b0;
      pulse_vnext();
      sweep(704);

      // 640 mode with blue border
      bus.i_mode   = 1'b1;
      bus.i_border = 6'h30;
      pulse_vnext();
      sweep(640);

      // Write coincident with swap lands in the new front buffer
      bus.i_wr_en   = 1'b1;
      bus.i_wr_idx  = 8'd5;
      bus.i_wr_data = 6'h2A;
      pulse_vnext();
      idle_inputs();
      sweep(640);

      // Line counter walk over a whole frame
      bus.i_vnewframe = 1'b1;
      step();
      bus.i_vnewframe = 1'b0;
      for (int k = 0; k < 270; k++) begin
         bus.i_hpos = 10'($urandom_range(0, 799));
         pulse_vnext();
         step();
      end

      // Randomised traffic
      for (int k = 0; k < 3000; k++) begin
         bus.i_hpos      = 10'($urandom_range(0, 799));
         bus.i_hblank    = ($urandom_range(0, 7) == 0);
         bus.i_vblank    = ($urandom_range(0, 7) == 0);
         bus.i_hsync     = 1'($urandom_range(0, 1));
         bus.i_vsync     = 1'($urandom_range(0, 1));
         bus.i_voddline  = 1'($urandom_range(0, 1));
         bus.i_border    = 6'($urandom_range(0, 63));
         bus.i_mode      = 1'($urandom_range(0, 1));
         bus.i_wr_en     = 1'($urandom_range(0, 1));
         bus.i_wr_idx    = 8'($urandom_range(0, 255));
         bus.i_wr_data   = 6'($urandom_range(0, 63));
         bus.i_vnext     = ($urandom_range(0, 49) == 0);
         bus.i_vnewframe = !bus.i_vnext && ($urandom_range(0, 199) == 0);
         step();
      end
      idle_inputs();

      // Reset in the middle of an active line
      bus.i_hblank = 1'b0;
      bus.i_vblank = 1'b0;
      bus.i_hpos   = 10'd300;
      repeat (4) step();
      #2 rst = 1'b1;
      #1 check_reset_outputs("midreset");
      vq.delete();
      rq.delete();
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 256; i++) begin
         bus.i_hblank  = 1'b1;
         bus.i_wr_en   = 1'b1;
         bus.i_wr_idx  = 8'(i);
         bus.i_wr_data = 6'($urandom_range(0, 63));
         step();
      end
      idle_inputs();
      bus.i_mode = 1'b0;
      pulse_vnext();
      sweep(704);

      repeat (3) step();
      repeat (2) @(negedge clk);
      chk("video_queue_drained", vq.size(), 0);
      chk("render_queue_drained", rq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
